// File: rtl/l2_cache_responder_if.sv
// rtl/l2_cache_responder_if.sv - L1 request/response and main-memory signals of the L2 cache responder
interface l2_cache_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] l1_addr;
    logic [DATA_WIDTH-1:0] l1_data_in;
    logic                  l1_read;
    logic                  l1_write;
    logic [DATA_WIDTH-1:0] l1_data_out;
    logic                  l1_ready;
    logic                  l1_hit;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_ready;

    // master is the surrounding system: L1 requester plus main memory
    modport master (
        output l1_addr, l1_data_in, l1_read, l1_write, mem_data_in, mem_ready,
        input  l1_data_out, l1_ready, l1_hit, mem_addr, mem_data_out, mem_read, mem_write
    );

    modport slave (
        input  l1_addr, l1_data_in, l1_read, l1_write, mem_data_in, mem_ready,
        output l1_data_out, l1_ready, l1_hit, mem_addr, mem_data_out, mem_read, mem_write
    );
endinterface

// File: rtl/l2_cache_responder.sv
// rtl/l2_cache_responder.sv - set-associative write-back L2 cache answering L1 requests
module l2_cache_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CACHE_SIZE = 4096,
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_WAYS   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    l2_cache_responder_if.slave  bus
);
    localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
    localparam int NUM_SETS    = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
    localparam int INDEX_BITS  = $clog2(NUM_SETS);
    localparam int LINE_BITS   = ADDR_WIDTH - OFFSET_BITS;
    localparam int TAG_BITS    = LINE_BITS - INDEX_BITS;
    localparam int WAY_BITS    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITE_BACK, ALLOCATE} state_t;

    state_t                state;
    logic [TAG_BITS-1:0]   tag_mem  [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0] data_mem [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]   valid    [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty    [NUM_SETS];
    logic [WAY_BITS-1:0]   rr_ptr   [NUM_SETS];

    logic                  armed;
    logic [LINE_BITS-1:0]  req_line;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  req_write;
    logic [WAY_BITS-1:0]   victim_way;

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  unused_offset;

    assign req_index     = req_line[INDEX_BITS-1:0];
    assign req_tag       = req_line[LINE_BITS-1 -: TAG_BITS];
    assign unused_offset = ^bus.l1_addr[OFFSET_BITS-1:0];

    logic                hit;
    logic [WAY_BITS-1:0] hit_way;
    logic                has_invalid;
    logic [WAY_BITS-1:0] invalid_way;
    logic [WAY_BITS-1:0] miss_way;
    logic                victim_dirty;

    // Descending scan so the lowest-numbered matching/invalid way wins.
    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        has_invalid = 1'b0;
        invalid_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid[req_index][w] && tag_mem[req_index][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!valid[req_index][w]) begin
                has_invalid = 1'b1;
                invalid_way = WAY_BITS'(w);
            end
        end
    end

    assign miss_way     = has_invalid ? invalid_way : rr_ptr[req_index];
    assign victim_dirty = valid[req_index][miss_way] && dirty[req_index][miss_way];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            armed            <= 1'b1;
            req_line         <= '0;
            req_data         <= '0;
            req_write        <= 1'b0;
            victim_way       <= '0;
            bus.l1_data_out  <= '0;
            bus.l1_ready     <= 1'b0;
            bus.l1_hit       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_data_out <= '0;
            bus.mem_read     <= 1'b0;
            bus.mem_write    <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s]  <= '0;
                dirty[s]  <= '0;
                rr_ptr[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    tag_mem[s][w]  <= '0;
                    data_mem[s][w] <= '0;
                end
            end
        end else begin
            // Re-arm only once L1 has dropped the previous request.
            if (!bus.l1_read && !bus.l1_write) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    bus.l1_ready <= 1'b0;
                    bus.l1_hit   <= 1'b0;
                    if (armed && (bus.l1_read || bus.l1_write)) begin
                        armed     <= 1'b0;
                        req_line  <= bus.l1_addr[ADDR_WIDTH-1:OFFSET_BITS];
                        req_data  <= bus.l1_data_in;
                        req_write <= bus.l1_write;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        bus.l1_hit   <= 1'b1;
                        bus.l1_ready <= 1'b1;
                        state        <= IDLE;
                        if (req_write) begin
                            data_mem[req_index][hit_way] <= req_data;
                            dirty[req_index][hit_way]    <= 1'b1;
                        end else begin
                            bus.l1_data_out <= data_mem[req_index][hit_way];
                        end
                    end else begin
                        victim_way <= miss_way;
                        if (!has_invalid) begin
                            rr_ptr[req_index] <= rr_ptr[req_index] + WAY_BITS'(1);
                        end
                        if (victim_dirty) begin
                            bus.mem_write    <= 1'b1;
                            bus.mem_addr     <= {tag_mem[req_index][miss_way], req_index, {OFFSET_BITS{1'b0}}};
                            bus.mem_data_out <= data_mem[req_index][miss_way];
                            state            <= WRITE_BACK;
                        end else if (!req_write) begin
                            bus.mem_read <= 1'b1;
                            bus.mem_addr <= {req_line, {OFFSET_BITS{1'b0}}};
                            state        <= ALLOCATE;
                        end else begin
                            // Write-allocate without fetch: the whole line is the written word.
                            tag_mem[req_index][miss_way]  <= req_tag;
                            data_mem[req_index][miss_way] <= req_data;
                            valid[req_index][miss_way]    <= 1'b1;
                            dirty[req_index][miss_way]    <= 1'b1;
                            bus.l1_ready                  <= 1'b1;
                            bus.l1_hit                    <= 1'b0;
                            state                         <= IDLE;
                        end
                    end
                end
                WRITE_BACK: begin
                    if (bus.mem_ready) begin
                        bus.mem_write <= 1'b0;
                        if (req_write) begin
                            tag_mem[req_index][victim_way]  <= req_tag;
                            data_mem[req_index][victim_way] <= req_data;
                            valid[req_index][victim_way]    <= 1'b1;
                            dirty[req_index][victim_way]    <= 1'b1;
                            bus.l1_ready                    <= 1'b1;
                            bus.l1_hit                      <= 1'b0;
                            state                           <= IDLE;
                        end else begin
                            bus.mem_read <= 1'b1;
                            bus.mem_addr <= {req_line, {OFFSET_BITS{1'b0}}};
                            state        <= ALLOCATE;
                        end
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ready) begin
                        tag_mem[req_index][victim_way]  <= req_tag;
                        data_mem[req_index][victim_way] <= bus.mem_data_in;
                        valid[req_index][victim_way]    <= 1'b1;
                        dirty[req_index][victim_way]    <= 1'b0;
                        bus.l1_data_out                 <= bus.mem_data_in;
                        bus.l1_ready                    <= 1'b1;
                        bus.l1_hit                      <= 1'b0;
                        bus.mem_read                    <= 1'b0;
                        state                           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_cache_responder.sv
// tb/tb_l2_cache_responder.sv - randomized self-checking bench for l2_cache_responder with a set/way reference model
module tb_l2_cache_responder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    l2_cache_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    l2_cache_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .CACHE_SIZE(4096), .BLOCK_SIZE(16), .NUM_WAYS(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_op_t;

    typedef struct {
        logic        hit;
        logic        rd;
        logic [31:0] data;
    } rsp_t;

    int checks   = 0;
    int failures = 0;

    mem_op_t mem_q[$];
    rsp_t    rsp_q[$];
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] phys_mem [logic [31:0]];

    logic        m_valid [64][4];
    logic        m_dirty [64][4];
    logic [21:0] m_tag   [64][4];
    logic [31:0] m_data  [64][4];
    int          m_rr    [64];

    int          mem_lat_fixed = -1;
    int          rsp_count = 0, n_mem_rd = 0, n_mem_wr = 0;
    logic [31:0] last_rd_addr, last_wb_addr, last_wb_data, last_rsp_data;
    logic        last_rsp_hit;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : mem_default(a);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
    endtask

    // Predicts the response and memory traffic of one request and updates the model cache.
    task automatic model_access(input logic [31:0] addr, input logic [31:0] wdata, input bit wr, output bit hit);
        int          s;
        int          w;
        logic [21:0] t;
        logic [31:0] line;
        logic [31:0] d;
        s    = int'(addr[9:4]);
        t    = addr[31:10];
        line = {addr[31:4], 4'h0};
        w    = -1;
        for (int i = 0; i < 4; i++) if (m_valid[s][i] && m_tag[s][i] == t) w = i;
        if (w >= 0) begin
            hit = 1'b1;
            if (wr) begin
                m_data[s][w]  = wdata;
                m_dirty[s][w] = 1'b1;
                rsp_q.push_back('{1'b1, 1'b0, 32'h0});
            end else begin
                rsp_q.push_back('{1'b1, 1'b1, m_data[s][w]});
            end
        end else begin
            hit = 1'b0;
            for (int i = 3; i >= 0; i--) if (!m_valid[s][i]) w = i;
            if (w < 0) begin
                w       = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % 4;
            end
            if (m_valid[s][w] && m_dirty[s][w]) begin
                mem_q.push_back('{1'b1, {m_tag[s][w], addr[9:4], 4'h0}, m_data[s][w]});
                ref_mem[{m_tag[s][w], addr[9:4], 4'h0}] = m_data[s][w];
            end
            m_valid[s][w] = 1'b1;
            m_tag[s][w]   = t;
            if (wr) begin
                m_data[s][w]  = wdata;
                m_dirty[s][w] = 1'b1;
                rsp_q.push_back('{1'b0, 1'b0, 32'h0});
            end else begin
                d = ref_rd(line);
                mem_q.push_back('{1'b0, line, 32'h0});
                m_data[s][w]  = d;
                m_dirty[s][w] = 1'b0;
                rsp_q.push_back('{1'b0, 1'b1, d});
            end
        end
    endtask

    // Compare process plus main-memory responder, both evaluated away from the active edge.
    mem_op_t cur_op;
    bit      mem_busy = 1'b0;
    int      mem_wait = 0;
    logic    prev_ready = 1'b0;
    rsp_t    r;

    always @(negedge clk) begin
        if (!rst_n) begin
            mem_busy      = 1'b0;
            bus.mem_ready = 1'b0;
            prev_ready    = 1'b0;
        end else begin
            chk("mem_rw_exclusive", 64'(bus.mem_read & bus.mem_write), 64'd0);
            if (bus.l1_ready) begin
                chk("l1_ready_pulse", 64'(prev_ready), 64'd0);
                chk("rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
                if (rsp_q.size() != 0) begin
                    r = rsp_q.pop_front();
                    chk("rsp_hit", 64'(bus.l1_hit), 64'(r.hit));
                    if (r.rd) chk("rsp_data", 64'(bus.l1_data_out), 64'(r.data));
                end
                rsp_count++;
                last_rsp_data = bus.l1_data_out;
                last_rsp_hit  = bus.l1_hit;
            end
            prev_ready = bus.l1_ready;
            if (mem_busy) begin
                if (bus.mem_ready) begin
                    bus.mem_ready = 1'b0;
                    mem_busy      = 1'b0;
                    if (!cur_op.wr) chk("refill_latency", 64'(bus.l1_ready), 64'd1);
                end else begin
                    chk("mem_hold", 64'({bus.mem_write, bus.mem_read, bus.mem_addr}),
                        64'({cur_op.wr, ~cur_op.wr, cur_op.addr}));
                    if (mem_wait == 0) begin
                        bus.mem_ready = 1'b1;
                        if (cur_op.wr) phys_mem[cur_op.addr] = cur_op.data;
                        else bus.mem_data_in = phys_rd(cur_op.addr);
                    end else begin
                        mem_wait--;
                    end
                end
            end else if (bus.mem_read || bus.mem_write) begin
                chk("mem_expected", 64'(mem_q.size() != 0), 64'd1);
                if (mem_q.size() != 0) begin
                    cur_op = mem_q.pop_front();
                    chk("mem_is_write", 64'(bus.mem_write), 64'(cur_op.wr));
                    chk("mem_addr", 64'(bus.mem_addr), 64'(cur_op.addr));
                    if (cur_op.wr) chk("mem_wb_data", 64'(bus.mem_data_out), 64'(cur_op.data));
                end
                cur_op.wr   = bus.mem_write;
                cur_op.addr = bus.mem_addr;
                cur_op.data = bus.mem_data_out;
                if (cur_op.wr) begin
                    n_mem_wr++;
                    last_wb_addr = cur_op.addr;
                    last_wb_data = cur_op.data;
                end else begin
                    n_mem_rd++;
                    last_rd_addr = cur_op.addr;
                end
                mem_busy = 1'b1;
                mem_wait = (mem_lat_fixed >= 0) ? mem_lat_fixed : int'($urandom_range(0, 3));
            end
        end
    end

    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input bit wr, input bit both,
                          input int hold, output bit hit);
        int lat;
        bit got;
        model_access(addr, wdata, wr, hit);
        @(posedge clk); #1;
        bus.l1_addr    = addr;
        bus.l1_data_in = wdata;
        bus.l1_write   = wr;
        bus.l1_read    = !wr || both;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            if (bus.l1_ready) got = 1'b1;
            else begin
                bus.l1_addr    = $urandom;
                bus.l1_data_in = $urandom;
            end
        end
        chk("l1_ready_timeout", 64'(got), 64'd1);
        if (hit) chk("hit_latency", 64'(lat), 64'd2);
        repeat (hold) begin @(posedge clk); #1; end
        bus.l1_read  = 1'b0;
        bus.l1_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk_outputs_zero(input string name);
        chk(name, 64'({bus.l1_ready, bus.l1_hit, bus.mem_read, bus.mem_write}), 64'd0);
        chk(name, 64'({bus.l1_data_out, bus.mem_data_out}), 64'd0);
        chk(name, 64'(bus.mem_addr), 64'd0);
    endtask

    bit          h;
    int          r0, w0, c0;
    bit          got;
    logic [31:0] a;

    initial begin
        bus.l1_addr    = '0;
        bus.l1_data_in = '0;
        bus.l1_read    = 1'b0;
        bus.l1_write   = 1'b0;
        bus.mem_data_in = '0;
        model_reset();
        ref_mem[32'h1230]  = 32'hDEAD_BEEF;
        phys_mem[32'h1230] = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset_outputs");
        rst_n = 1'b1;

        // Cold read miss, then the same line again as a hit
        mem_lat_fixed = 2;
        r0 = n_mem_rd; w0 = n_mem_wr;
        do_req(32'h0000_1230, 32'h0, 1'b0, 1'b0, 0, h);
        chk("cold_model_miss", 64'(h), 64'd0);
        chk("cold_mem_reads", 64'(n_mem_rd - r0), 64'd1);
        chk("cold_rd_addr", 64'(last_rd_addr), 64'h1230);
        chk("cold_data", 64'(last_rsp_data), 64'hDEAD_BEEF);
        chk("cold_hit", 64'(last_rsp_hit), 64'd0);
        r0 = n_mem_rd;
        do_req(32'h0000_1234, 32'h0, 1'b0, 1'b0, 0, h);
        chk("rehit_mem_reads", 64'(n_mem_rd - r0), 64'd0);
        chk("rehit_data", 64'(last_rsp_data), 64'hDEAD_BEEF);
        chk("rehit_hit", 64'(last_rsp_hit), 64'd1);
        mem_lat_fixed = -1;

        // Write miss allocates without memory traffic
        r0 = n_mem_rd; w0 = n_mem_wr;
        do_req(32'h0000_0400, 32'h1111_0000, 1'b1, 1'b0, 0, h);
        chk("wmiss_no_mem", 64'((n_mem_rd - r0) + (n_mem_wr - w0)), 64'd0);
        chk("wmiss_hit", 64'(last_rsp_hit), 64'd0);
        do_req(32'h0000_0400, 32'h0, 1'b0, 1'b0, 0, h);
        chk("wmiss_readback", 64'(last_rsp_data), 64'h1111_0000);
        chk("wmiss_readback_hit", 64'(last_rsp_hit), 64'd1);

        // Asynchronous reset while the refill is outstanding
        mem_lat_fixed = 20;
        model_access(32'h0000_2340, 32'h0, 1'b0, h);
        @(posedge clk); #1;
        bus.l1_addr = 32'h0000_2340;
        bus.l1_read = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            got = bus.mem_read;
        end
        chk("alloc_reached", 64'(got), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_outputs_zero("reset_in_allocate");
        bus.l1_read = 1'b0;
        mem_q.delete();
        rsp_q.delete();
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_lat_fixed = -1;
        r0 = n_mem_rd;
        do_req(32'h0000_2340, 32'h0, 1'b0, 1'b0, 0, h);
        chk("post_reset_miss", 64'(n_mem_rd - r0), 64'd1);
        chk("post_reset_rd_addr", 64'(last_rd_addr), 64'h2340);

        // Fill set 0 with dirty lines, then force write-back evictions
        do_req(32'h0000_0000, 32'hA000_0000, 1'b1, 1'b0, 0, h);
        do_req(32'h0000_0400, 32'hA111_1111, 1'b1, 1'b0, 0, h);
        do_req(32'h0000_0800, 32'hA222_2222, 1'b1, 1'b0, 0, h);
        do_req(32'h0000_0C00, 32'hA333_3333, 1'b1, 1'b0, 0, h);
        w0 = n_mem_wr;
        do_req(32'h0000_1000, 32'h0, 1'b0, 1'b0, 0, h);
        chk("evict0_wb_count", 64'(n_mem_wr - w0), 64'd1);
        chk("evict0_wb_addr", 64'(last_wb_addr), 64'h0);
        chk("evict0_wb_data", 64'(last_wb_data), 64'hA000_0000);
        chk("evict0_rd_addr", 64'(last_rd_addr), 64'h1000);
        do_req(32'h0000_1400, 32'h0, 1'b0, 1'b0, 0, h);
        chk("evict1_wb_addr", 64'(last_wb_addr), 64'h400);
        chk("evict1_wb_data", 64'(last_wb_data), 64'hA111_1111);

        // Request held after completion is served once
        c0 = rsp_count;
        do_req(32'h0000_1000, 32'h0, 1'b0, 1'b0, 4, h);
        chk("held_req_once", 64'(rsp_count - c0), 64'd1);

        // Read and write together behave as a write
        do_req(32'h0000_5670, 32'h0BAD_F00D, 1'b1, 1'b1, 0, h);
        do_req(32'h0000_5670, 32'h0, 1'b0, 1'b0, 0, h);
        chk("both_as_write", 64'(last_rsp_data), 64'h0BAD_F00D);

        for (int k = 0; k < 300; k++) begin
            a = ($urandom_range(0, 5) << 10) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
            do_req(a, $urandom, ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0),
                   int'($urandom_range(0, 3)), h);
        end

        repeat (10) @(posedge clk);
        #1;
        chk("drain_mem_q", 64'(mem_q.size()), 64'd0);
        chk("drain_rsp_q", 64'(rsp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end
endmodule
